// File: rtl/wb_ext_sram_bridge_if.sv
// Wishbone classic bus bundle between the arbitrated core master and the SRAM bridge.
interface wb_ext_sram_bridge_if;
  localparam int unsigned ADR_W = 24;
  localparam int unsigned DAT_W = 16;
  localparam int unsigned SEL_W = 2;

  logic             wb_cyc;
  logic             wb_stb;
  logic             wb_we;
  logic [ADR_W-1:0] wb_adr;
  logic [SEL_W-1:0] wb_sel;
  logic [DAT_W-1:0] wb_i_dat;
  logic [DAT_W-1:0] wb_o_dat;
  logic             wb_ack;
  logic             wb_err;
  logic             wb_rty;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_i_dat,
    input  wb_o_dat, wb_ack, wb_err, wb_rty
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_i_dat,
    output wb_o_dat, wb_ack, wb_err, wb_rty
  );
endinterface

// File: rtl/wb_ext_sram_bridge.sv
// Wishbone slave that splits each 16-bit transfer into per-lane accesses on an 8-bit async SRAM.
// Pins are a registered decode of the FSM state, so they trail the state by one cycle.
module wb_ext_sram_bridge #(
  parameter int unsigned MEM_AW      = 19,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  wb_ext_sram_bridge_if.slave wb,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_dq_o,
  input  logic [7:0]        mem_dq_i,
  output logic              mem_dq_oe,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n
);
  localparam int unsigned WA_W      = MEM_AW - 1;
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [WA_W-1:0]   adr_q, adr_d;
  logic [1:0]        sel_q, sel_d;
  logic [15:0]       dat_q, dat_d;
  logic              lane_q, lane_d;
  logic              bad_q, bad_d;
  logic              abort_q, abort_d;
  logic [15:0]       rd_q, rd_d;

  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [15:0]       o_dat_q, o_dat_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [7:0]        dq_o_q, dq_o_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;

  logic              active;
  logic              out_of_range;

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      lane_q  <= 1'b0;
      bad_q   <= 1'b0;
      abort_q <= 1'b0;
      rd_q    <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      o_dat_q <= '0;
      addr_q  <= '0;
      dq_o_q  <= '0;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      lane_q  <= lane_d;
      bad_q   <= bad_d;
      abort_q <= abort_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      o_dat_q <= o_dat_d;
      addr_q  <= addr_d;
      dq_o_q  <= dq_o_d;
      dq_oe_q <= dq_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
    end
  end

  assign active       = (state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD);
  assign out_of_range = (wb.wb_adr >> WA_W) != 24'd0;

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    lane_d  = lane_q;
    bad_d   = bad_q;
    abort_d = abort_q;
    rd_d    = rd_q;
    o_dat_d = o_dat_q;
    addr_d  = addr_q;
    dq_o_d  = dq_o_q;

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        // The IDLE cycle carrying the previous ack/err pin must not re-accept the same stb.
        if (wb.wb_cyc && wb.wb_stb && !ack_q && !err_q) begin
          we_d   = wb.wb_we;
          adr_d  = wb.wb_adr[WA_W-1:0];
          sel_d  = wb.wb_sel;
          dat_d  = wb.wb_i_dat;
          rd_d   = '0;
          cnt_d  = '0;
          bad_d  = out_of_range;
          lane_d = !wb.wb_sel[0];
          if (out_of_range || (wb.wb_sel == 2'b00)) state_d = RESP;
          else                                      state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        abort_d = abort_q || !wb.wb_cyc;
        state_d = STROBE;
      end
      STROBE: begin
        abort_d = abort_q || !wb.wb_cyc;
        if (cnt_q == WAIT_LAST) state_d = HOLD;
        else                    cnt_d   = cnt_q + 4'd1;
      end
      HOLD: begin
        // Pins still show the final strobe cycle here, so read data is valid now.
        if (!we_q) begin
          if (lane_q) rd_d[15:8] = mem_dq_i;
          else        rd_d[7:0]  = mem_dq_i;
        end
        if (abort_q || !wb.wb_cyc) begin
          state_d = IDLE;
        end else if (!lane_q && sel_q[1]) begin
          lane_d  = 1'b1;
          state_d = SETUP;
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (!bad_q && !we_q) o_dat_d = rd_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q == SETUP) begin
      addr_d = {adr_q, lane_q};
      dq_o_d = lane_q ? dat_q[15:8] : dat_q[7:0];
    end

    ack_d   = (state_q == RESP) && !bad_q;
    err_d   = (state_q == RESP) && bad_q;
    ce_n_d  = !active;
    dq_oe_d = active && we_q;
    oe_n_d  = !((state_q == STROBE) && !we_q);
    we_n_d  = !((state_q == STROBE) && we_q);
  end

  assign wb.wb_ack   = ack_q;
  assign wb.wb_err   = err_q;
  assign wb.wb_rty   = 1'b0;
  assign wb.wb_o_dat = o_dat_q;
  assign mem_addr    = addr_q;
  assign mem_dq_o    = dq_o_q;
  assign mem_dq_oe   = dq_oe_q;
  assign mem_ce_n    = ce_n_q;
  assign mem_oe_n    = oe_n_q;
  assign mem_we_n    = we_n_q;
endmodule

// File: tb/tb_wb_ext_sram_bridge.sv
// Directed bench for wb_ext_sram_bridge with a byte-wide async SRAM model (MEM_AW=19, WAIT=1).
module tb_wb_ext_sram_bridge;
  logic        i_clk;
  logic        i_rst;
  logic [18:0] mem_addr;
  logic [7:0]  mem_dq_o;
  logic [7:0]  mem_dq_i;
  logic        mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n;

  wb_ext_sram_bridge_if wb();

  wb_ext_sram_bridge #(.MEM_AW(19), .WAIT_CYCLES(1)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .wb        (wb),
    .mem_addr  (mem_addr),
    .mem_dq_o  (mem_dq_o),
    .mem_dq_i  (mem_dq_i),
    .mem_dq_oe (mem_dq_oe),
    .mem_ce_n  (mem_ce_n),
    .mem_oe_n  (mem_oe_n),
    .mem_we_n  (mem_we_n)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // SRAM model: 256 bytes aliased on addr[7:0], preset to i^A5, written on we_n rising.
  logic [7:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    forever begin
      @(posedge mem_we_n);
      if (mem_ce_n === 1'b0) mem[mem_addr[7:0]] = mem_dq_o;
    end
  end
  assign mem_dq_i = (mem_ce_n === 1'b0 && mem_oe_n === 1'b0) ? mem[mem_addr[7:0]] : 8'h00;

  int ce_tot, we_tot, oe_tot, resp_tot, both_cnt, we_no_oe_cnt, rw_both_cnt;
  initial begin
    ce_tot = 0; we_tot = 0; oe_tot = 0; resp_tot = 0;
    both_cnt = 0; we_no_oe_cnt = 0; rw_both_cnt = 0;
  end
  always @(negedge i_clk) begin
    if (i_rst) begin
      if (!mem_ce_n) ce_tot <= ce_tot + 1;
      if (!mem_we_n) we_tot <= we_tot + 1;
      if (!mem_oe_n) oe_tot <= oe_tot + 1;
      if (wb.wb_ack || wb.wb_err) resp_tot <= resp_tot + 1;
      if (wb.wb_ack && wb.wb_err) both_cnt <= both_cnt + 1;
      if (!mem_we_n && !mem_dq_oe) we_no_oe_cnt <= we_no_oe_cnt + 1;
      if (!mem_we_n && !mem_oe_n) rw_both_cnt <= rw_both_cnt + 1;
    end
  end

  typedef struct {
    logic        we;
    logic [23:0] adr;
    logic [1:0]  sel;
    logic [15:0] dat;
    int          nb;
    logic        exp_err;
    logic [15:0] exp_rdat;
    int          exp_lat;
  } vec_t;

  int checks, errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic xfer(input vec_t v, output logic ack, output logic err,
                      output logic [15:0] rd, output int lat);
    wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1; wb.wb_we = v.we;
    wb.wb_adr = v.adr; wb.wb_sel = v.sel; wb.wb_i_dat = v.dat;
    lat = -1; ack = 1'b0; err = 1'b0; rd = '0;
    for (int n = 0; n < 100 && lat < 0; n++) begin
      @(posedge i_clk); #1;
      if (wb.wb_ack || wb.wb_err) begin
        lat = n; ack = wb.wb_ack; err = wb.wb_err; rd = wb.wb_o_dat;
      end
    end
    wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL xfer_timeout actual=no_response required=ack_or_err");
    end
    @(posedge i_clk); #1;
    chk("resp_single_cycle", 32'(wb.wb_ack | wb.wb_err), 32'd0);
  endtask

  vec_t        vecs [13];
  vec_t        v;
  logic        g_ack, g_err;
  logic [15:0] g_rd;
  int          g_lat, ce0, we0, oe0, r0;

  initial begin
    checks = 0; errors = 0;
    vecs[0]  = '{1'b1, 24'h000010, 2'b11, 16'hBEEF, 2, 1'b0, 16'h0000, 9};
    vecs[1]  = '{1'b0, 24'h000010, 2'b10, 16'h0000, 1, 1'b0, 16'hBE00, 5};
    vecs[2]  = '{1'b0, 24'h000010, 2'b11, 16'h0000, 2, 1'b0, 16'hBEEF, 9};
    vecs[3]  = '{1'b0, 24'h000010, 2'b01, 16'h0000, 1, 1'b0, 16'h00EF, 5};
    vecs[4]  = '{1'b1, 24'h040000, 2'b11, 16'h1111, 0, 1'b1, 16'h0000, 1};
    vecs[5]  = '{1'b1, 24'h000020, 2'b00, 16'h2222, 0, 1'b0, 16'h0000, 1};
    vecs[6]  = '{1'b1, 24'h000003, 2'b01, 16'h1234, 1, 1'b0, 16'h0000, 5};
    vecs[7]  = '{1'b0, 24'h000003, 2'b11, 16'h0000, 2, 1'b0, 16'hA234, 9};
    vecs[8]  = '{1'b1, 24'h000003, 2'b10, 16'h5600, 1, 1'b0, 16'h0000, 5};
    vecs[9]  = '{1'b0, 24'h000003, 2'b11, 16'h0000, 2, 1'b0, 16'h5634, 9};
    vecs[10] = '{1'b0, 24'hFFFFFF, 2'b11, 16'h0000, 0, 1'b1, 16'h0000, 1};
    vecs[11] = '{1'b0, 24'h000020, 2'b00, 16'h0000, 0, 1'b0, 16'h0000, 1};
    vecs[12] = '{1'b0, 24'h03FFFF, 2'b01, 16'h0000, 1, 1'b0, 16'h005B, 5};

    i_rst = 1'b0;
    wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0; wb.wb_we = 1'b0;
    wb.wb_adr = '0; wb.wb_sel = '0; wb.wb_i_dat = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ack", 32'(wb.wb_ack), 32'd0);
    chk("rst_err", 32'(wb.wb_err), 32'd0);
    chk("rst_rty", 32'(wb.wb_rty), 32'd0);
    chk("rst_o_dat", 32'(wb.wb_o_dat), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_dq_o", 32'(mem_dq_o), 32'd0);
    chk("rst_dq_oe", 32'(mem_dq_oe), 32'd0);
    chk("rst_ce_n", 32'(mem_ce_n), 32'd1);
    chk("rst_oe_n", 32'(mem_oe_n), 32'd1);
    chk("rst_we_n", 32'(mem_we_n), 32'd1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;

    for (int i = 0; i < 13; i++) begin
      ce0 = ce_tot; we0 = we_tot; oe0 = oe_tot;
      xfer(vecs[i], g_ack, g_err, g_rd, g_lat);
      chk($sformatf("v%0d_ack", i), 32'(g_ack), 32'(!vecs[i].exp_err));
      chk($sformatf("v%0d_err", i), 32'(g_err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_lat", i), 32'(g_lat), 32'(vecs[i].exp_lat));
      if (!vecs[i].we && !vecs[i].exp_err)
        chk($sformatf("v%0d_rdat", i), 32'(g_rd), 32'(vecs[i].exp_rdat));
      chk($sformatf("v%0d_ce_cycles", i), 32'(ce_tot - ce0), 32'(vecs[i].nb * 4));
      chk($sformatf("v%0d_we_cycles", i), 32'(we_tot - we0), vecs[i].we ? 32'(vecs[i].nb * 2) : 32'd0);
      chk($sformatf("v%0d_oe_cycles", i), 32'(oe_tot - oe0), vecs[i].we ? 32'd0 : 32'(vecs[i].nb * 2));
    end
    chk("mem_20", 32'(mem[8'h20]), 32'hEF);
    chk("mem_21", 32'(mem[8'h21]), 32'hBE);
    chk("mem_06", 32'(mem[8'h06]), 32'h34);
    chk("mem_07", 32'(mem[8'h07]), 32'h56);

    // cyc dropped during the first byte of a two-byte write
    r0 = resp_tot; we0 = we_tot;
    wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1; wb.wb_we = 1'b1;
    wb.wb_adr = 24'h000008; wb.wb_sel = 2'b11; wb.wb_i_dat = 16'h9A77;
    repeat (3) @(posedge i_clk);
    #1;
    wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0;
    repeat (15) @(posedge i_clk);
    #1;
    chk("abort_no_resp", 32'(resp_tot - r0), 32'd0);
    chk("abort_we_cycles", 32'(we_tot - we0), 32'd2);
    chk("abort_ce_idle", 32'(mem_ce_n), 32'd1);
    chk("abort_mem_10", 32'(mem[8'h10]), 32'h77);
    chk("abort_mem_11", 32'(mem[8'h11]), 32'hB4);
    v = '{1'b0, 24'h000008, 2'b11, 16'h0000, 2, 1'b0, 16'hB477, 9};
    xfer(v, g_ack, g_err, g_rd, g_lat);
    chk("abort_rd_ack", 32'(g_ack), 32'd1);
    chk("abort_rd_lat", 32'(g_lat), 32'd9);
    chk("abort_rd_dat", 32'(g_rd), 32'hB477);

    // asynchronous reset while oe_n is low
    wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1; wb.wb_we = 1'b0;
    wb.wb_adr = 24'h000010; wb.wb_sel = 2'b11;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rstmid_oe_active", 32'(mem_oe_n), 32'd0);
    i_rst = 1'b0;
    #1;
    chk("rstmid_ce_n", 32'(mem_ce_n), 32'd1);
    chk("rstmid_oe_n", 32'(mem_oe_n), 32'd1);
    chk("rstmid_we_n", 32'(mem_we_n), 32'd1);
    chk("rstmid_dq_oe", 32'(mem_dq_oe), 32'd0);
    wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    r0 = resp_tot;
    repeat (15) @(posedge i_clk);
    #1;
    chk("rstmid_no_ack", 32'(resp_tot - r0), 32'd0);
    v = '{1'b0, 24'h000010, 2'b11, 16'h0000, 2, 1'b0, 16'hBEEF, 9};
    xfer(v, g_ack, g_err, g_rd, g_lat);
    chk("rstmid_rd_lat", 32'(g_lat), 32'd9);
    chk("rstmid_rd_dat", 32'(g_rd), 32'hBEEF);

    chk("ack_err_together", 32'(both_cnt), 32'd0);
    chk("we_without_dq_oe", 32'(we_no_oe_cnt), 32'd0);
    chk("oe_we_together", 32'(rw_both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
